// File: rtl/exmem_arb_pkg.sv
// Shared types and defaults for the exmem BRAM arbiter.
package exmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int unsigned DELAYS_DEF    = 10;
  localparam logic [11:0] ADDR_BASE_DEF = 12'h380;

  localparam logic WB  = 1'b0;
  localparam logic USR = 1'b1;

endpackage

// File: rtl/exmem_rr_arb.sv
// Two-way round-robin picker: prio selects the winner only when both ports request.
module exmem_rr_arb
  import exmem_arb_pkg::*;
(
  input  logic req_wb,
  input  logic req_usr,
  input  logic prio,
  output logic gnt_vld,
  output logic gnt_idx
);

  always_comb begin
    gnt_vld = req_wb | req_usr;
    if (req_wb && req_usr) begin
      gnt_idx = prio;
    end else if (req_usr) begin
      gnt_idx = USR;
    end else begin
      gnt_idx = WB;
    end
  end

endmodule

// File: rtl/exmem_bram_arbiter.sv
// Shares one single-port BRAM between the Wishbone slave and the engine port,
// holding the BRAM for DELAYS+1 cycles per access before acking the grantee.
module exmem_bram_arbiter
  import exmem_arb_pkg::*;
#(
  parameter int unsigned DELAYS    = DELAYS_DEF,
  parameter logic [11:0] ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        u_req_i,
  input  logic        u_we_i,
  input  logic [3:0]  u_sel_i,
  input  logic [31:0] u_adr_i,
  input  logic [31:0] u_dat_i,
  output logic        u_ack_o,
  output logic [31:0] u_dat_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_adr_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i
);

  localparam int unsigned CW = $clog2(DELAYS + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic            grant_q, grant_d;
  logic            we_q, we_d;
  logic [31:0]     adr_d, di_d, wdat_d, udat_d;
  logic [3:0]      bwe_d;
  logic            en_d, wack_d, uack_d;
  logic            wb_req, gnt_vld, gnt_idx, grant_req;

  assign wb_req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == ADDR_BASE);
  assign grant_req = (grant_q == USR) ? u_req_i : wb_req;

  exmem_rr_arb u_rr_arb (
    .req_wb  (wb_req),
    .req_usr (u_req_i),
    .prio    (prio_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    we_d    = we_q;
    adr_d   = bram_adr_o;
    di_d    = bram_di_o;
    wdat_d  = wbs_dat_o;
    udat_d  = u_dat_o;
    en_d    = 1'b0;
    bwe_d   = 4'h0;
    wack_d  = 1'b0;
    uack_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = BUSY;
          cnt_d   = '0;
          grant_d = gnt_idx;
          en_d    = 1'b1;
          if (gnt_idx == USR) begin
            adr_d = u_adr_i;
            di_d  = u_dat_i;
            we_d  = u_we_i;
            bwe_d = u_sel_i & {4{u_we_i}};
          end else begin
            adr_d = wbs_adr_i;
            di_d  = wbs_dat_i;
            we_d  = wbs_we_i;
            bwe_d = wbs_sel_i & {4{wbs_we_i}};
          end
        end
      end
      BUSY: begin
        // Write strobes were only loaded on entry, so each write lands once.
        if (cnt_q == CW'(DELAYS)) begin
          state_d = ACK;
          cnt_d   = '0;
          if (!we_q) begin
            if (grant_q == USR) udat_d = bram_do_i;
            else                wdat_d = bram_do_i;
          end
          if (grant_q == USR) uack_d = u_req_i;
          else                wack_d = wb_req;
        end else begin
          cnt_d = cnt_q + CW'(1);
          en_d  = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        prio_d  = ~grant_q;
      end
      default: state_d = IDLE;
    endcase
    if (state_q == BUSY && cnt_q == CW'(DELAYS) && !grant_req) begin
      wack_d = 1'b0;
      uack_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prio_q     <= WB;
      grant_q    <= WB;
      we_q       <= 1'b0;
      bram_en_o  <= 1'b0;
      bram_we_o  <= 4'h0;
      bram_adr_o <= '0;
      bram_di_o  <= '0;
      wbs_ack_o  <= 1'b0;
      u_ack_o    <= 1'b0;
      wbs_dat_o  <= '0;
      u_dat_o    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      bram_en_o  <= en_d;
      bram_we_o  <= bwe_d;
      bram_adr_o <= adr_d;
      bram_di_o  <= di_d;
      wbs_ack_o  <= wack_d;
      u_ack_o    <= uack_d;
      wbs_dat_o  <= wdat_d;
      u_dat_o    <= udat_d;
    end
  end

endmodule

// File: doc/exmem_bram_arbiter.md
# exmem_bram_arbiter

Arbitrates one single-port user BRAM between the Wishbone slave path and a user-side engine port, for example the FIR coefficient/data fetcher. Each access holds the BRAM for a fixed programmable latency, then acks. This matches the exmem timing model firmware is written against. The block sits in the user project between the Wishbone slave decode, the engine, and the `bram` macro, and owns every BRAM control pin.

## Interface
- `DELAYS`, 10: extra BRAM hold cycles per access (≥1); total busy window is DELAYS+1 cycles.
- `ADDR_BASE`, 12'h380: Wishbone decode value compared against `wbs_adr_i[31:20]`.

- `wb_clk_i` in 1: single clock; all state on rising edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic request.
- `wbs_sel_i` in 4: byte strobes.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle ack.
- `wbs_dat_o` out 32: registered read data.
- `u_req_i`, `u_we_i` in 1 each: engine request and write flag.
- `u_sel_i` in 4: engine byte strobes.
- `u_adr_i` in 32: engine byte address.
- `u_dat_i` in 32: engine write data.
- `u_ack_o` out 1: one-cycle ack.
- `u_dat_o` out 32: registered read data.
- `bram_en_o` out 1: BRAM enable.
- `bram_we_o` out 4: BRAM byte write enables.
- `bram_adr_o` out 32: BRAM address.
- `bram_di_o` out 32: BRAM write data.
- `bram_do_i` in 32: BRAM read data, valid one cycle after enable with address.

## Operation
- The Wishbone request is `wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20]==ADDR_BASE)`. A non-decoded Wishbone cycle is never granted and never acked. The engine port has no decode.
- FSM states:
  - IDLE: no request → stay. One request → grant it. Both requesting → grant per round-robin pointer `prio` (0 = Wishbone, 1 = engine). Latch grantee's address, data, `sel`, and `we`. Go to BUSY with `cnt=0`.
  - BUSY: `bram_en_o=1`. Latched address and data are driven. `bram_we_o = sel & {4{we}}` only when `cnt==0`, otherwise 0, so each write is issued exactly once. `cnt` increments each cycle. When `cnt==DELAYS`, capture `bram_do_i` into the grantee's `*_dat_o` (reads only) and go to ACK.
  - ACK: pulse grantee's `*_ack_o` for one cycle. Set `prio` to the non-grantee. Go to IDLE.
- The ack is gated by the grantee's request still being asserted in ACK. If the request was withdrawn mid-access, the BRAM access still completes, a write stays committed, and no ack is issued. `prio` still rotates.
- A write ack leaves `*_dat_o` unchanged. The non-granted port's outputs never change.
- Requesters hold their request and all request fields stable until ack. Latched copies make mid-access field changes harmless.

## Timing
- Request sampled in IDLE at cycle T. BUSY spans T+1 … T+DELAYS+1. Ack is high at T+DELAYS+2. The next IDLE is at T+DELAYS+3.
- Minimum spacing between accesses is DELAYS+3 cycles. Back-to-back contention alternates grantees strictly.
- Reset values:
  - FSM=IDLE, `cnt=0`, `prio=0`.
  - All acks 0, `bram_en_o=0`, `bram_we_o=0`.
  - `bram_adr_o`, `bram_di_o`, `wbs_dat_o`, `u_dat_o` = 0.
- Reset mid-access: the FSM returns to IDLE the next cycle with no ack. A write issued at `cnt==0` is not undone.

## Structure
- Package `exmem_arb_pkg` holds:
  - State encoding IDLE/BUSY/ACK.
  - Default `DELAYS` and `ADDR_BASE`.
  - Port index constants WB=0 and USR=1.
- Sub-module `exmem_rr_arb` is the two-way round-robin picker. Inputs: two requests and `prio`. Outputs: a grant-valid flag and the grant index. It is purely combinational.
- The FSM, counter, latches, and BRAM drive live in the top module.

## Test plan
- Wishbone write then read, no contention: write 0xDEADBEEF at 0x3800_0010 with sel=4'hF, then read the same address. Each ack arrives exactly DELAYS+2 cycles after the request; read returns 0xDEADBEEF. `bram_we_o` is nonzero in exactly one cycle.
- Byte strobe: write 0x11223344 at 0x3800_0020 with sel=4'h2, then read. Only byte 1 changes.
- Contention with `prio=0` after reset: Wishbone and engine request at the same cycle. Wishbone is acked first; the engine is acked DELAYS+3 cycles later. In the next simultaneous round the engine wins.
- Non-decoded Wishbone cycle at 0x3000_0000 held for 40 cycles: no ack, `bram_en_o` stays 0, and engine requests are still served.
- Reset asserted at `cnt==3` of an engine read: the next cycle shows IDLE with all acks 0. After release, a Wishbone read is served normally with `prio=0`.
- Engine withdraws `u_req_i` mid-write: the data is in the BRAM on readback, `u_ack_o` is never asserted, and `prio` has rotated.
